// File: rtl/ripple_count_monitor.sv
`default_nettype none
// ============================================================================
// Module   : ripple_count_monitor
// Purpose  : Synchronises and debounces a ripple counter's outputs, checks the
//            count sequence and drives the counter's mod-N active-low clear.
// Revision : 1.0
// ============================================================================
module ripple_count_monitor #(
  parameter int WIDTH      = 4,
  parameter int MODULUS    = 10,
  parameter int STABLE     = 2,
  parameter int CLR_CYCLES = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] cnt_in,
  output logic             cnt_clr_n,
  output logic [WIDTH-1:0] cnt_out,
  output logic             valid,
  output logic             tc,
  output logic [7:0]       wraps,
  output logic             seq_err
);

  localparam int c_STAB_W = (STABLE > 1) ? $clog2(STABLE) : 1;
  localparam int c_TMR_W  = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam bit c_NATURAL = (MODULUS == (1 << WIDTH));

  localparam logic [c_STAB_W-1:0] c_STAB_MAX = c_STAB_W'(STABLE - 1);
  localparam logic [c_STAB_W-1:0] c_STAB_ONE = c_STAB_W'(1);
  localparam logic [c_TMR_W-1:0]  c_TMR_INIT = c_TMR_W'(CLR_CYCLES - 1);
  localparam logic [c_TMR_W-1:0]  c_TMR_ONE  = c_TMR_W'(1);
  localparam logic [WIDTH-1:0]    c_MOD_VAL  = WIDTH'(MODULUS);
  localparam logic [WIDTH-1:0]    c_CNT_ONE  = WIDTH'(1);

  typedef enum logic [1:0] {
    ST_COUNT     = 2'd0,
    ST_CLEAR     = 2'd1,
    ST_WAIT_ZERO = 2'd2
  } state_t;

  state_t              r_state;
  logic [WIDTH-1:0]    r_s1;
  logic [WIDTH-1:0]    r_s2;
  logic [WIDTH-1:0]    r_cand;
  logic [c_STAB_W-1:0] r_stab;
  logic [WIDTH-1:0]    r_cnt_out;
  logic                r_valid;
  logic                r_tc;
  logic [7:0]          r_wraps;
  logic                r_seq_err;
  logic                r_clr_n;
  logic [c_TMR_W-1:0]  r_timer;

  logic                w_accept;
  logic [WIDTH-1:0]    w_next;

  // A value is taken once it has sat unchanged at s2 for STABLE+1 edges.
  assign w_accept = (r_s2 == r_cand) && (r_stab == c_STAB_MAX) && (r_cand != r_cnt_out);
  assign w_next   = r_cnt_out + c_CNT_ONE;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_cand    <= '0;
      r_stab    <= '0;
      r_cnt_out <= '0;
      r_valid   <= 1'b0;
      r_tc      <= 1'b0;
      r_wraps   <= 8'd0;
      r_seq_err <= 1'b0;
      r_clr_n   <= 1'b1;
      r_timer   <= '0;
      r_state   <= ST_COUNT;
    end else begin
      r_s1    <= cnt_in;
      r_s2    <= r_s1;
      r_valid <= 1'b0;
      r_tc    <= 1'b0;

      if (r_s2 != r_cand) begin
        r_cand <= r_s2;
        r_stab <= '0;
      end else if (r_stab != c_STAB_MAX) begin
        r_stab <= r_stab + c_STAB_ONE;
      end

      if (w_accept) begin
        r_cnt_out <= r_cand;
        r_valid   <= 1'b1;
      end

      case (r_state)
        ST_COUNT: begin
          if (w_accept) begin
            if (r_cand != w_next) begin
              r_seq_err <= 1'b1;
            end
            if (!c_NATURAL && (r_cand == c_MOD_VAL)) begin
              r_state <= ST_CLEAR;
              r_clr_n <= 1'b0;
              r_timer <= c_TMR_INIT;
            end else if (c_NATURAL && (r_cand == '0) && (r_cnt_out == '1)) begin
              r_tc    <= 1'b1;
              r_wraps <= r_wraps + 8'd1;
            end
          end
        end
        ST_CLEAR: begin
          if (r_timer == '0) begin
            r_clr_n <= 1'b1;
            r_state <= ST_WAIT_ZERO;
          end else begin
            r_timer <= r_timer - c_TMR_ONE;
          end
        end
        ST_WAIT_ZERO: begin
          if (w_accept && (r_cand != '0)) begin
            r_seq_err <= 1'b1;
          end
          // The counter may already read zero if its clear landed during CLEAR.
          if ((r_cnt_out == '0) || (w_accept && (r_cand == '0))) begin
            r_state <= ST_COUNT;
            r_tc    <= 1'b1;
            r_wraps <= r_wraps + 8'd1;
          end
        end
        default: begin
          r_state <= ST_COUNT;
        end
      endcase
    end
  end

  assign cnt_clr_n = r_clr_n;
  assign cnt_out   = r_cnt_out;
  assign valid     = r_valid;
  assign tc        = r_tc;
  assign wraps     = r_wraps;
  assign seq_err   = r_seq_err;

endmodule
`default_nettype wire
